// File: rtl/data_memory.sv
// Word-addressed data memory answering the core's load/store requests.
// Accepts one request every two cycles and returns an aligned, extended result one cycle later.
module data_memory #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              store_enable,
    input  logic              load_enable,
    input  logic [3:0]        mem_write_enable,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       write_data,
    output logic              rsp_valid,
    output logic [31:0]       read_data,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic {IDLE, RESP} state_t;
    typedef enum logic [1:0] {KIND_NULL, KIND_STORE, KIND_LOAD} kind_t;

    state_t state_q, state_d;
    kind_t  kind_in, kind_q;

    logic [2:0]       func3_q;
    logic [1:0]       off_q;
    logic             err_q;
    logic [31:0]      rd_word_q;
    logic [31:0]      mem [DEPTH_WORDS];

    logic             fire;
    logic             out_of_range;
    logic             misaligned;
    logic             err_in;
    logic [IDX_W-1:0] word_idx;
    logic [3:0]       lane_strb;
    logic [31:0]      lane_data;
    logic [31:0]      lane;

    assign req_ready = rst_n && (state_q == IDLE);
    assign fire      = req_valid && req_ready;

    assign word_idx     = addr[IDX_W+1:2];
    assign out_of_range = |addr[ADDR_W-1:IDX_W+2];
    assign lane_strb    = mem_write_enable << addr[1:0];
    assign lane_data    = write_data << {addr[1:0], 3'b000};

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        kind_in = KIND_NULL;
        if (store_enable)     kind_in = KIND_STORE;
        else if (load_enable) kind_in = KIND_LOAD;

        misaligned = 1'b0;
        case (func3)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = addr[0];
            3'b010:         misaligned = (addr[1:0] != 2'b00);
            default:        misaligned = 1'b1;
        endcase

        err_in = (kind_in != KIND_NULL) && (out_of_range || misaligned);
    end

    // NOTE: the memory array and its read register are deliberately not reset; only control state is.
    always_ff @(posedge clk) begin
        if (fire && kind_in == KIND_STORE && !err_in) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_strb[b]) mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
        if (fire) rd_word_q <= mem[word_idx];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            kind_q  <= KIND_NULL;
            func3_q <= 3'b000;
            off_q   <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                kind_q  <= kind_in;
                func3_q <= func3;
                off_q   <= addr[1:0];
                err_q   <= err_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fire) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response is built purely from captured state, never from the live request inputs.
    assign rsp_valid = (state_q == RESP);
    assign err       = rsp_valid && err_q;
    assign lane      = rd_word_q >> {off_q, 3'b000};

    always_comb begin
        read_data = '0;
        if (rsp_valid && kind_q == KIND_LOAD && !err_q) begin
            case (func3_q)
                3'b000:  read_data = {{24{lane[7]}}, lane[7:0]};
                3'b001:  read_data = {{16{lane[15]}}, lane[15:0]};
                3'b010:  read_data = rd_word_q;
                3'b100:  read_data = {24'h0, lane[7:0]};
                3'b101:  read_data = {16'h0, lane[15:0]};
                default: read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed vector table, hand-written
// back-to-back and reset-in-RESP sequences, then randomized traffic against a byte-level model.
module tb_data_memory;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        store_enable = 1'b0;
    logic        load_enable = 1'b0;
    logic [3:0]  mem_write_enable = 4'h0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic        rsp_valid;
    logic [31:0] read_data;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mb [4*DEPTH];

    data_memory #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .store_enable(store_enable), .load_enable(load_enable),
        .mem_write_enable(mem_write_enable), .func3(func3), .addr(addr),
        .write_data(write_data), .rsp_valid(rsp_valid), .read_data(read_data), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          st;
        bit          ld;
        logic [3:0]  we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        bit          e;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic void add(input string name, input bit st, input bit ld, input logic [3:0] we,
                                input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input bit e);
        vec_t v;
        v.name = name; v.st = st; v.ld = ld; v.we = we; v.f3 = f3;
        v.a = a; v.wd = wd; v.rd = rd; v.e = e;
        vecs.push_back(v);
    endfunction

    // One full request: present at a negedge, handshake on the next posedge,
    // sample the response at the following negedge.
    task automatic access(input bit st, input bit ld, input logic [3:0] we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic rv, output logic [31:0] rd, output logic e, output logic rdy);
        @(negedge clk);
        store_enable = st; load_enable = ld; mem_write_enable = we;
        func3 = f3; addr = a; write_data = wd; req_valid = 1'b1;
        rdy = req_ready;
        @(negedge clk);
        req_valid = 1'b0;
        rv = rsp_valid; rd = read_data; e = err;
    endtask

    function automatic bit model_err(input bit st, input bit ld, input logic [2:0] f3, input logic [31:0] a);
        if (!st && !ld) return 1'b0;
        if (a >= 32'(4*DEPTH)) return 1'b1;
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (a % 2) != 0;
            3'd2:       return (a % 4) != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic void model_store(input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
        int base = int'(a) & ~3;
        int off  = int'(a) % 4;
        for (int k = 0; k < 4; k++)
            if (we[k] && off + k < 4) mb[base + off + k] = wd[8*k +: 8];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        logic [31:0] v = 32'h0;
        for (int k = 0; k < size; k++) v = v | (32'(mb[int'(a) + k]) << (8*k));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
        return v;
    endfunction

    initial begin
        logic        rv, e, rdy;
        logic [31:0] rd;
        int          n_rsp;

        // Reset state
        #2;
        check("reset_ready", {31'h0, req_ready}, 32'h0);
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset_read_data", read_data, 32'h0);
        check("reset_err", {31'h0, err}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        #1 check("ready_after_reset", {31'h0, req_ready}, 32'h1);

        // Directed vectors (applied in order; later entries depend on earlier stores)
        add("sw_deadbeef", 1, 0, 4'hF, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        add("lw_deadbeef", 0, 1, 4'hF, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        add("sw_zero",     1, 0, 4'hF, 3'd2, 32'h10, 32'h0, 32'h0, 0);
        add("sb_a5",       1, 0, 4'h1, 3'd0, 32'h13, 32'h000000A5, 32'h0, 0);
        add("lw_after_sb", 0, 1, 4'hF, 3'd2, 32'h10, 32'h0, 32'hA5000000, 0);
        add("lb_13",       0, 1, 4'h1, 3'd0, 32'h13, 32'h0, 32'hFFFFFFA5, 0);
        add("lbu_13",      0, 1, 4'h1, 3'd4, 32'h13, 32'h0, 32'h000000A5, 0);
        add("sh_8001",     1, 0, 4'h3, 3'd1, 32'h12, 32'h00008001, 32'h0, 0);
        add("lh_12",       0, 1, 4'h3, 3'd1, 32'h12, 32'h0, 32'hFFFF8001, 0);
        add("lhu_12",      0, 1, 4'h3, 3'd5, 32'h12, 32'h0, 32'h00008001, 0);
        add("lw_after_sh", 0, 1, 4'hF, 3'd2, 32'h10, 32'h0, 32'h80010000, 0);
        add("sw_misalign", 1, 0, 4'hF, 3'd2, 32'h11, 32'h12345678, 32'h0, 1);
        add("lh_misalign", 0, 1, 4'h3, 3'd1, 32'h13, 32'h0, 32'h0, 1);
        add("lw_unchanged",0, 1, 4'hF, 3'd2, 32'h10, 32'h0, 32'h80010000, 0);
        add("sw_word0",    1, 0, 4'hF, 3'd2, 32'h0, 32'h11111111, 32'h0, 0);
        add("sw_oor",      1, 0, 4'hF, 3'd2, 32'(4*DEPTH), 32'h22222222, 32'h0, 1);
        add("lw_word0",    0, 1, 4'hF, 3'd2, 32'h0, 32'h0, 32'h11111111, 0);
        add("lw_oor",      0, 1, 4'hF, 3'd2, 32'(4*DEPTH), 32'h0, 32'h0, 1);
        add("null_access", 0, 0, 4'hF, 3'd2, 32'h10, 32'hFFFFFFFF, 32'h0, 0);
        add("strobe_zero", 1, 0, 4'h0, 3'd2, 32'h10, 32'hFFFFFFFF, 32'h0, 0);
        add("lw_after_s0", 0, 1, 4'hF, 3'd2, 32'h10, 32'h0, 32'h80010000, 0);
        add("ld_reserved", 0, 1, 4'hF, 3'd3, 32'h10, 32'h0, 32'h0, 1);
        add("st_and_ld",   1, 1, 4'hF, 3'd2, 32'h20, 32'h12345678, 32'h0, 0);
        add("lw_st_and_ld",0, 1, 4'hF, 3'd2, 32'h20, 32'h0, 32'h12345678, 0);

        foreach (vecs[i]) begin
            access(vecs[i].st, vecs[i].ld, vecs[i].we, vecs[i].f3, vecs[i].a, vecs[i].wd, rv, rd, e, rdy);
            check({vecs[i].name, "_ready"}, {31'h0, rdy}, 32'h1);
            check({vecs[i].name, "_rsp_valid"}, {31'h0, rv}, 32'h1);
            check({vecs[i].name, "_data"}, rd, vecs[i].rd);
            check({vecs[i].name, "_err"}, {31'h0, e}, {31'h0, vecs[i].e});
        end

        // Back-to-back: req_valid held high, one response per accepted request
        @(negedge clk);
        store_enable = 1'b0; load_enable = 1'b1; func3 = 3'd2; addr = 32'h10; req_valid = 1'b1;
        n_rsp = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("b2b_ready_%0d", i), {31'h0, req_ready}, {31'h0, (i % 2) == 0});
            check($sformatf("b2b_rsp_%0d", i), {31'h0, rsp_valid}, {31'h0, (i % 2) == 1});
            if (rsp_valid) begin
                n_rsp++;
                check($sformatf("b2b_data_%0d", i), read_data, 32'h80010000);
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_rsp_count", n_rsp, 4);
        check("b2b_no_extra_rsp", {31'h0, rsp_valid}, 32'h0);

        // Reset while a load is in RESP: response is dropped, prior store survives
        access(1, 0, 4'hF, 3'd2, 32'h30, 32'hCAFEF00D, rv, rd, e, rdy);
        @(negedge clk);
        store_enable = 1'b0; load_enable = 1'b1; func3 = 3'd2; addr = 32'h30; req_valid = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check("rst_rsp_dropped", {31'h0, rsp_valid}, 32'h0);
        check("rst_ready_low", {31'h0, req_ready}, 32'h0);
        check("rst_data_zero", read_data, 32'h0);
        check("rst_err_zero", {31'h0, err}, 32'h0);
        @(negedge clk);
        check("rst_rsp_still_low", {31'h0, rsp_valid}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'h0, req_ready}, 32'h1);
        check("post_rst_rsp", {31'h0, rsp_valid}, 32'h0);
        access(0, 1, 4'hF, 3'd2, 32'h30, 32'h0, rv, rd, e, rdy);
        check("store_persists", rd, 32'hCAFEF00D);

        // Randomized traffic over the first 16 words plus occasional out-of-range addresses
        for (int w = 0; w < 16; w++) begin
            logic [31:0] v = $urandom;
            access(1, 0, 4'hF, 3'd2, 32'(4*w), v, rv, rd, e, rdy);
            model_store(4'hF, 32'(4*w), v);
        end
        for (int i = 0; i < 300; i++) begin
            int          r = $urandom_range(0, 9);
            bit          st = (r < 4);
            bit          ld = (r >= 4 && r < 9);
            logic [3:0]  we;
            logic [2:0]  f3;
            logic [31:0] a, wd, exp_rd;
            bit          exp_e;
            int          sel = $urandom_range(0, 2);
            if (st) begin
                f3 = 3'(sel);
                we = (sel == 0) ? 4'h1 : (sel == 1) ? 4'h3 : 4'hF;
                if ($urandom_range(0, 11) == 0) we = 4'h0;
                if ($urandom_range(0, 14) == 0) f3 = 3'd3;
            end else begin
                we = 4'h0;
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
                if ($urandom_range(0, 14) == 0) f3 = 3'($urandom_range(6, 7));
            end
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) a = 32'(4*DEPTH) + 32'($urandom_range(0, 100000));
            wd = $urandom;
            exp_e  = model_err(st, ld, f3, a);
            exp_rd = (ld && !st && !exp_e) ? model_load(f3, a) : 32'h0;
            access(st, ld, we, f3, a, wd, rv, rd, e, rdy);
            if (st && !exp_e) model_store(we, a, wd);
            check($sformatf("rand_%0d_rsp", i), {31'h0, rv}, 32'h1);
            check($sformatf("rand_%0d_data", i), rd, exp_rd);
            check($sformatf("rand_%0d_err", i), {31'h0, e}, {31'h0, exp_e});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Word-addressed data memory that serves as the responder for the core's store/load path. It consumes the unshifted byte-strobe pattern and `func3` produced by instruction decode, aligns strobes and data to the byte offset, and performs writes. It returns sign- or zero-extended load data one cycle after acceptance. It sits between the execute stage and the register-file writeback mux.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two.
- ADDR_W, 32: byte-address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  access request present.
- req_ready  output  1  block can accept a request this cycle.
- store_enable  input  1  request is a store.
- load_enable  input  1  request is a load.
- mem_write_enable  input  4  unshifted byte strobes from decode: 0001 (SB), 0011 (SH), 1111 (SW).
- func3  input  3  load/store width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- addr  input  ADDR_W  byte address.
- write_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  one-cycle pulse: access complete.
- read_data  output  32  extended load data; valid only with rsp_valid for a load, else 0.
- err  output  1  valid with rsp_valid: misaligned or out-of-range access.

## Operation
- FSM states: IDLE, RESP. Reset state is IDLE.
- req_ready is 1 in IDLE and 0 in RESP.
- Handshake fires when req_valid && req_ready. Inputs are sampled only on the handshake edge.
- On handshake: capture kind, func3, addr[1:0] and error status; go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then return to IDLE. Each request occupies two cycles.
- Kind:
  - store_enable=1 means store, regardless of load_enable.
  - store_enable=0 with load_enable=1 means load.
  - Both 0 means a null access: rsp_valid pulses, err=0, read_data=0, no write.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Out-of-range means any addr bit above that field is nonzero; it sets err.
- Misaligned:
  - halfword (func3[1:0]=01) with addr[0]=1;
  - word (func3[1:0]=10) with addr[1:0]≠00;
  - reserved func3 (011, 11x) also sets err.
- Store:
  - lane strobes = mem_write_enable << addr[1:0];
  - lane data = write_data << (8*addr[1:0]);
  - written on the handshake edge, but only if err=0;
  - strobe value 0000 writes nothing and is not an error.
- Load:
  - word read on the handshake edge; lane selected by the captured addr[1:0];
  - B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through;
  - err=1 forces read_data=0.
- Memory array is not reset. Contents are undefined until written.

## Timing
- Reset values: req_ready=1 (once rst_n deasserts; 0 during reset), rsp_valid=0, read_data=0, err=0, state IDLE.
- Latency: rsp_valid asserts in the cycle after the handshake; read_data and err are stable only in that cycle.
- Store data is visible to a load accepted on any later handshake (no read-during-write hazard possible with the two-cycle occupancy).
- Requests presented while req_ready=0 are ignored and must be held by the initiator.
- rst_n asserted in RESP: state goes to IDLE immediately and the pending response is dropped. A store already written on the handshake edge is not rolled back.
- No combinational path from request inputs to rsp_valid, read_data or err.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10 -> rsp_valid one cycle after each handshake; read_data=0xDEADBEEF, err=0.
- SB 0xA5 to 0x13 over 0x00000000, then LW 0x10 -> 0xA5000000. LB 0x13 -> 0xFFFFFFA5. LBU 0x13 -> 0x000000A5.
- SH 0x8001 to 0x12, then LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001. Word at 0x10 keeps its lower half unchanged.
- SW to 0x11 and LH from 0x13 -> err=1 with rsp_valid. Memory is unchanged (LW 0x10 returns the prior value). read_data=0.
- Address 4*DEPTH_WORDS -> err=1, no write. Back-to-back req_valid held high -> req_ready alternates 1/0 and exactly one rsp_valid per accepted request.
- rst_n pulsed low during RESP of a load -> rsp_valid never asserts for it. Outputs return to 0 and req_ready=1 after rst_n deasserts. A store before the reset persists.
